multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle MIPS CPU; sits directly upstream of ALUop and drives its ALUctr input.
//  Decodes the IR opcode and sequences FETCH/DECODE/EXEC/MEM/WB.
//  Emits every datapath enable/mux select as a Moore function of state.
//  The ALU decoder combines ALUctr with func to produce ALU_op.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode (ALUctr=10, func decoded by ALUop)
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_J      6'b000010  jump
//  OP_ADDI   6'b001000  add immediate
//  OP_ORI    6'b001101  or immediate (ALUctr=11)
// PORTS
//  clk       in   1  rising-edge clock
//  rst       in   1  synchronous, active-high reset
//  op        in   6  IR[31:26], valid from DECODE onward
//  zero      in   1  ALU zero flag, sampled in BEQ state
//  ALUctr    out  2  00 add, 01 sub, 10 use func, 11 or -> ALUop
//  ALUSrcA   out  1  0 PC, 1 rs
//  ALUSrcB   out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sext imm<<2
//  PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
//  pc_en     out  1  PCWrite | (PCWriteCond & zero)
//  IorD      out  1  0 PC addr, 1 ALUOut addr
//  MemRead/MemWrite/IRWrite/RegWrite  out  1 each  strobes
//  RegDst    out  1  0 rt, 1 rd;   MemtoReg out 1  0 ALUOut, 1 MDR
//  state     out  4  current state (debug)
//  instr_done out 1  high in the last cycle of each instruction
// BEHAVIOUR
//  States (4'd): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 RTEX6 RTWB7 BEQ8 JMP9 IMMEX10 IMMWB11 HALT12.
//  - Reset: while rst=1 at a rising edge, state<=FETCH.
//    All outputs are forced to 0 combinationally while rst=1.
//    Reset mid-instruction aborts it with no write strobes.
//  - FETCH: MemRead, IRWrite, ALUSrcB=01, ALUctr=00, PCWrite (PC+4). Next: DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUctr=00 (branch target into ALUOut). Next by op:
//    lw/sw->MEMADR, R->RTEX, beq->BEQ, j->JMP, addi/ori->IMMEX.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUctr=00; lw->MEMRD, sw->MEMWR.
//  - MEMRD: MemRead, IorD=1 -> MEMWB.  MEMWB: RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
//  - MEMWR: MemWrite, IorD=1 -> FETCH.
//  - RTEX: ALUSrcA=1, ALUSrcB=00, ALUctr=10 -> RTWB.  RTWB: RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
//  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUctr=01, PCWriteCond, PCSource=01 -> FETCH.
//    pc_en=zero in this state.
//  - JMP: PCWrite, PCSource=10 -> FETCH.
//  - IMMEX: ALUSrcA=1, ALUSrcB=10, ALUctr=00 (addi) or 11 (ori); op is re-read, IR stable.
//    Next: IMMWB.  IMMWB: RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
//  - Cycle counts: lw 5; R/sw/addi/ori 4; beq/j 3.
//    instr_done=1 in MEMWB, MEMWR, RTWB, BEQ, JMP, IMMWB.
//  - Outputs not listed for a state are 0. State encodings 13-15 go to FETCH on the next edge.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    Unknown op in DECODE -> HALT; all outputs 0 except state=12.
//    HALT holds until rst; no PC/reg/mem writes.
//  ILLEGAL_TRAP_EN undefined:
//    Unknown op in DECODE -> FETCH (treated as NOP; PC already +4); DECODE asserts instr_done.
// TESTING
//  1. rst=1 for 2 cycles, op=x -> all outputs 0. After release, state=0, MemRead=IRWrite=pc_en=1.
//  2. op=000000 -> states 0,1,6,7. ALUctr=10 in RTEX; RegWrite=RegDst=1 in RTWB; instr_done only in cycle 4.
//  3. op=100011 then op=101011 -> lw 0,1,2,3,4 (MemtoReg=1 in 4); sw 0,1,2,5 (MemWrite=1, IorD=1 in 5).
//  4. op=000100 with zero=1 -> BEQ: ALUctr=01, PCSource=01, pc_en=1. Repeat with zero=0 -> pc_en=0.
//  5. op=001101 -> IMMEX ALUctr=11, ALUSrcB=10; op=001000 -> ALUctr=00; both then IMMWB with RegWrite=1.
//  6. op=111111 -> trap build: state 12 held 5 cycles, no strobes, rst recovers to 0.
//     Non-trap build: 0,1,0. Also rst asserted in MEMRD -> next state 0, MemWrite never high.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle MIPS CPU. It decodes the IR opcode,
//   steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
//   datapath enable and mux select as a Moore function of the current state.
//   ALUctr feeds the downstream ALU decoder (ALUop), which merges it with func.
//
//   Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to a HALT
//   state that holds until reset. When it is left undefined, an unknown opcode
//   is retired in DECODE as a NOP.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; forces all outputs to 0
//   op         in   IR[31:26], valid from DECODE onward
//   zero       in   ALU zero flag, used in the BEQ state
//   ALUctr     out  00 add, 01 sub, 10 use func, 11 or
//   ALUSrcA    out  0 PC, 1 rs
//   ALUSrcB    out  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//   PCSource   out  00 ALU result, 01 ALUOut, 10 jump target
//   pc_en      out  PCWrite | (PCWriteCond & zero)
//   IorD       out  0 PC address, 1 ALUOut address
//   MemRead, MemWrite, IRWrite, RegWrite   out  strobes
//   RegDst     out  0 rt, 1 rd
//   MemtoReg   out  0 ALUOut, 1 MDR
//   state      out  current state (debug)
//   instr_done out  high in the last cycle of each instruction
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_ORI   = 6'b001101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       zero,
   output logic [1:0] ALUctr,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       pc_en,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [3:0] state,
   output logic       instr_done
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEX   = 4'd6,
      RTWB   = 4'd7,
      BEQ    = 4'd8,
      JMP    = 4'd9,
      IMMEX  = 4'd10,
      IMMWB  = 4'd11,
      HALT   = 4'd12
   } state_t;

   typedef struct packed {
      logic [1:0] alu_ctr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       done;
   } ctl_t;

   state_t cur;
   state_t nxt;
   ctl_t   ctl_r;
   ctl_t   ctl_nxt;
   logic   op_known;

   always_comb begin
      op_known = (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)   ||
                 (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI) ||
                 (op == OP_ORI);
   end

   // Next-state logic; reset overrides so the control word loaded alongside
   // the state register always describes the state being entered.
   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH:  nxt = DECODE;
         DECODE: begin
            if ((op == OP_LW) || (op == OP_SW))
               nxt = MEMADR;
            else if (op == OP_RTYPE)
               nxt = RTEX;
            else if (op == OP_BEQ)
               nxt = BEQ;
            else if (op == OP_J)
               nxt = JMP;
            else if ((op == OP_ADDI) || (op == OP_ORI))
               nxt = IMMEX;
            else
`ifdef ILLEGAL_TRAP_EN
               nxt = HALT;
`else
               nxt = FETCH;
`endif
         end
         MEMADR: nxt = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  nxt = MEMWB;
         RTEX:   nxt = RTWB;
         IMMEX:  nxt = IMMWB;
         HALT:   nxt = HALT;
         default: nxt = FETCH;
      endcase
      if (rst)
         nxt = FETCH;
   end

   // Control word for the state being entered. Registering it keeps the
   // outputs glitch-free while remaining a pure function of state. IMMEX's
   // add/or choice samples op at the DECODE->IMMEX edge; IR is stable then.
   always_comb begin
      ctl_nxt = '0;
      case (nxt)
         FETCH: begin
            ctl_nxt.mem_read  = 1'b1;
            ctl_nxt.ir_write  = 1'b1;
            ctl_nxt.alu_src_b = 2'b01;
            ctl_nxt.pc_write  = 1'b1;
         end
         DECODE: ctl_nxt.alu_src_b = 2'b11;
         MEMADR: begin
            ctl_nxt.alu_src_a = 1'b1;
            ctl_nxt.alu_src_b = 2'b10;
         end
         MEMRD: begin
            ctl_nxt.mem_read = 1'b1;
            ctl_nxt.iord     = 1'b1;
         end
         MEMWB: begin
            ctl_nxt.reg_write  = 1'b1;
            ctl_nxt.mem_to_reg = 1'b1;
            ctl_nxt.done       = 1'b1;
         end
         MEMWR: begin
            ctl_nxt.mem_write = 1'b1;
            ctl_nxt.iord      = 1'b1;
            ctl_nxt.done      = 1'b1;
         end
         RTEX: begin
            ctl_nxt.alu_src_a = 1'b1;
            ctl_nxt.alu_ctr   = 2'b10;
         end
         RTWB: begin
            ctl_nxt.reg_write = 1'b1;
            ctl_nxt.reg_dst   = 1'b1;
            ctl_nxt.done      = 1'b1;
         end
         BEQ: begin
            ctl_nxt.alu_src_a     = 1'b1;
            ctl_nxt.alu_ctr       = 2'b01;
            ctl_nxt.pc_write_cond = 1'b1;
            ctl_nxt.pc_source     = 2'b01;
            ctl_nxt.done          = 1'b1;
         end
         JMP: begin
            ctl_nxt.pc_write  = 1'b1;
            ctl_nxt.pc_source = 2'b10;
            ctl_nxt.done      = 1'b1;
         end
         IMMEX: begin
            ctl_nxt.alu_src_a = 1'b1;
            ctl_nxt.alu_src_b = 2'b10;
            ctl_nxt.alu_ctr   = (op == OP_ORI) ? 2'b11 : 2'b00;
         end
         IMMWB: begin
            ctl_nxt.reg_write = 1'b1;
            ctl_nxt.done      = 1'b1;
         end
         default: ctl_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         cur <= FETCH;
      else
         cur <= nxt;
      ctl_r <= ctl_nxt;
   end

   // Outputs are forced low while reset is held, so an instruction aborted
   // mid-flight never emits a write strobe.
   always_comb begin
      ALUctr     = rst ? 2'b00 : ctl_r.alu_ctr;
      ALUSrcA    = !rst && ctl_r.alu_src_a;
      ALUSrcB    = rst ? 2'b00 : ctl_r.alu_src_b;
      PCSource   = rst ? 2'b00 : ctl_r.pc_source;
      pc_en      = !rst && (ctl_r.pc_write || (ctl_r.pc_write_cond && zero));
      IorD       = !rst && ctl_r.iord;
      MemRead    = !rst && ctl_r.mem_read;
      MemWrite   = !rst && ctl_r.mem_write;
      IRWrite    = !rst && ctl_r.ir_write;
      RegWrite   = !rst && ctl_r.reg_write;
      RegDst     = !rst && ctl_r.reg_dst;
      MemtoReg   = !rst && ctl_r.mem_to_reg;
      state      = rst ? 4'd0 : cur;
`ifdef ILLEGAL_TRAP_EN
      instr_done = !rst && ctl_r.done;
`else
      // An unknown opcode retires as a NOP in DECODE; op is only valid from
      // DECODE onward, so this term is taken from the live opcode.
      instr_done = !rst && (ctl_r.done || ((cur == DECODE) && !op_known));
`endif
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. The stimulus process walks each
//   instruction through the state sequence it should take and pushes the
//   expected output vector for every cycle; a monitor pops and compares at the
//   falling edge. Honours ILLEGAL_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   typedef logic [19:0] vec_t;

   localparam logic [5:0] RTY  = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQO = 6'b000100;
   localparam logic [5:0] JO   = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = '0;
   logic       zero = 1'b0;
   logic [1:0] ALUctr, ALUSrcB, PCSource;
   logic       ALUSrcA, pc_en, IorD, MemRead, MemWrite, IRWrite;
   logic       RegWrite, RegDst, MemtoReg, instr_done;
   logic [3:0] state;

   vec_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero),
      .ALUctr(ALUctr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .pc_en(pc_en), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .state(state), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   function automatic logic is_legal(input logic [5:0] o);
      return o inside {RTY, LW, SW, BEQO, JO, ADDI, ORI};
   endfunction

   // Expected outputs for one cycle, straight from the per-state output rules.
   function automatic vec_t model(input int st, input logic [5:0] o,
                                  input logic z, input logic r);
      logic [1:0] alu, b, pcs;
      logic a, pcen, iord, mr, mw, irw, rw, rd, m2r, dn;
      alu = '0; b = '0; pcs = '0;
      a = 0; pcen = 0; iord = 0; mr = 0; mw = 0; irw = 0;
      rw = 0; rd = 0; m2r = 0; dn = 0;
      if (r) return '0;
      case (st)
         0:  begin mr = 1; irw = 1; b = 2'b01; pcen = 1; end
         1:  begin
                b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
                dn = !is_legal(o);
`endif
             end
         2:  begin a = 1; b = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; dn = 1; end
         5:  begin mw = 1; iord = 1; dn = 1; end
         6:  begin a = 1; alu = 2'b10; end
         7:  begin rw = 1; rd = 1; dn = 1; end
         8:  begin a = 1; alu = 2'b01; pcs = 2'b01; pcen = z; dn = 1; end
         9:  begin pcen = 1; pcs = 2'b10; dn = 1; end
         10: begin a = 1; b = 2'b10; alu = (o == ORI) ? 2'b11 : 2'b00; end
         11: begin rw = 1; dn = 1; end
         default: ;
      endcase
      return {4'(st), alu, a, b, pcs, pcen, iord, mr, mw, irw, rw, rd, m2r, dn};
   endfunction

   // One cycle: drive inputs just after the rising edge, queue the expectation.
   task automatic cyc(input int st, input logic [5:0] o, input logic z,
                      input logic r);
      @(posedge clk);
      #1;
      rst  = r;
      op   = o;
      zero = z;
      exp_q.push_back(model(st, o, z, r));
   endtask

   // Runs one instruction; abort_at >= 0 replaces that cycle with a reset.
   task automatic run_instr(input logic [5:0] o, input int zsel,
                            input int abort_at);
      int seq[$];
      logic [5:0] junk;
      logic z;
      seq = {0, 1};
      case (o)
         LW:         seq = {0, 1, 2, 3, 4};
         SW:         seq = {0, 1, 2, 5};
         RTY:        seq = {0, 1, 6, 7};
         BEQO:       seq = {0, 1, 8};
         JO:         seq = {0, 1, 9};
         ADDI, ORI:  seq = {0, 1, 10, 11};
         default: begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < 5; k++) seq.push_back(12);
`endif
         end
      endcase
      foreach (seq[i]) begin
         junk = 6'($urandom);
         z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
         if (i == abort_at) begin
            cyc(0, junk, z, 1'b1);
            return;
         end
         cyc(seq[i], (i == 0) ? junk : o, z, 1'b0);
      end
`ifdef ILLEGAL_TRAP_EN
      if (!is_legal(o)) cyc(0, 6'($urandom), 1'($urandom), 1'b1);
`endif
   endtask

   // Monitor
   initial begin
      vec_t e, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {state, ALUctr, ALUSrcA, ALUSrcB, PCSource, pc_en, IorD,
                   MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                   instr_done};
            vectors++;
            if (act !== e) begin
               miscompares++;
               $display("FAIL ctl_vec #%0d t=%0t op=%b zero=%b rst=%b: got %h expected %h (state got %0d expected %0d)",
                        vectors, $time, op, zero, rst, act, e, act[19:16], e[19:16]);
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [5:0] legal_ops [7];
      logic [5:0] o;
      int ab;
      legal_ops = '{RTY, LW, SW, BEQO, JO, ADDI, ORI};

      // Reset held for two cycles with junk opcode.
      cyc(0, 6'($urandom), 1'b1, 1'b1);
      cyc(0, 6'($urandom), 1'b0, 1'b1);

      // Directed instructions.
      run_instr(RTY, -1, -1);
      run_instr(LW, -1, -1);
      run_instr(SW, -1, -1);
      run_instr(BEQO, 1, -1);
      run_instr(BEQO, 0, -1);
      run_instr(ORI, -1, -1);
      run_instr(ADDI, -1, -1);
      run_instr(JO, -1, -1);
      run_instr(6'b111111, -1, -1);
      run_instr(LW, -1, 3);          // reset while in MEMRD
      run_instr(SW, -1, -1);

      // Randomised instruction stream.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0)
            o = 6'($urandom);
         else
            o = legal_ops[$urandom_range(0, 6)];
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(o, -1, ab);
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d queued expectations, required 0", exp_q.size());
      end
      if (vectors < 12) begin
         miscompares++;
         $display("FAIL vector_count: got %0d compared, required at least 12", vectors);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
